// File: rtl/rv64_pkg.sv
// Shared RV64 definitions: writeback source select and load funct3 encodings.
package rv64_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  // Contents of the single writeback stage register.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        reg_write;
    wb_sel_e     wb_sel;
    logic [63:0] alu_result;
    logic [63:0] pc_plus4;
    logic [63:0] mem_rdata;
    logic [2:0]  addr_lo;
    logic [2:0]  funct3;
  } wb_stage_t;

endpackage

// File: rtl/load_align.sv
// Load data extraction/extension by funct3 and byte offset, plus misalignment
// and illegal-type detection. Purely combinational.
module load_align
  import rv64_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [63:0] data,
  output logic        misaligned,
  output logic        illegal
);

  logic [63:0] byte_sh;
  logic [63:0] half_sh;
  logic [63:0] word_sh;

  // Bring the addressed lane down to bit 0; shift amounts are lane index * lane width.
  assign byte_sh = rdata >> {addr_lo, 3'b000};
  assign half_sh = rdata >> {addr_lo[2:1], 4'b0000};
  assign word_sh = rdata >> {addr_lo[2], 5'b00000};

  // NOTE: every output of a combinational block gets a default first so that no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    data       = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    unique case (funct3)
      F3_LB:  data = {{56{byte_sh[7]}}, byte_sh[7:0]};
      F3_LBU: data = {56'd0, byte_sh[7:0]};
      F3_LH: begin
        data       = {{48{half_sh[15]}}, half_sh[15:0]};
        misaligned = addr_lo[0];
      end
      F3_LHU: begin
        data       = {48'd0, half_sh[15:0]};
        misaligned = addr_lo[0];
      end
      F3_LW: begin
        data       = {{32{word_sh[31]}}, word_sh[31:0]};
        misaligned = (addr_lo[1:0] != 2'b00);
      end
      F3_LWU: begin
        data       = {32'd0, word_sh[31:0]};
        misaligned = (addr_lo[1:0] != 2'b00);
      end
      F3_LD: begin
        data       = rdata;
        misaligned = (addr_lo != 3'b000);
      end
      F3_BAD:  illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// RV64 writeback stage: one stage register feeding the register-file write port.
// Optional retire counter output retire_count when WB_RETIRE_CNT_EN is defined.
module writeback_stage
  import rv64_pkg::*;
#(
  parameter int RETIRE_W = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        hold,
  input  logic        flush,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  input  logic [1:0]  in_wb_sel,
  input  logic [63:0] in_alu_result,
  input  logic [63:0] in_pc_plus4,
  input  logic [63:0] in_mem_rdata,
  input  logic [2:0]  in_addr_lo,
  input  logic [2:0]  in_funct3,
  output logic [4:0]  rf_rd,
  output logic [63:0] rf_write_data,
  output logic        rf_write_enable,
  output logic        exc_misaligned,
  output logic        retire_valid
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [RETIRE_W-1:0] retire_count
`endif
);

  wb_stage_t   stage;
  logic        capture;
  logic [63:0] load_data;
  logic        load_misaligned;
  logic        load_illegal;
  logic        is_load;
  logic        write_ok;
  logic [63:0] wb_value;

  assign in_ready = !hold;
  assign capture  = in_valid && in_ready && !flush;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator runs blocks in.
  // The datapath fields are reset along with valid so that nothing downstream
  // ever sees X, even though valid alone gates every output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else if (!hold) begin
      if (capture) begin
        stage.valid      <= 1'b1;
        stage.rd         <= in_rd;
        stage.reg_write  <= in_reg_write;
        stage.wb_sel     <= wb_sel_e'(in_wb_sel);
        stage.alu_result <= in_alu_result;
        stage.pc_plus4   <= in_pc_plus4;
        stage.mem_rdata  <= in_mem_rdata;
        stage.addr_lo    <= in_addr_lo;
        stage.funct3     <= in_funct3;
      end else begin
        stage.valid <= 1'b0;
      end
    end
  end

  load_align u_load_align (
    .rdata      (stage.mem_rdata),
    .addr_lo    (stage.addr_lo),
    .funct3     (stage.funct3),
    .data       (load_data),
    .misaligned (load_misaligned),
    .illegal    (load_illegal)
  );

  assign is_load = (stage.wb_sel == WB_LOAD);

  always_comb begin
    wb_value = stage.alu_result;
    unique case (stage.wb_sel)
      WB_ALU:  wb_value = stage.alu_result;
      WB_LOAD: wb_value = load_data;
      WB_PC4:  wb_value = stage.pc_plus4;
      WB_RSVD: wb_value = '0;
      default: wb_value = '0;
    endcase
  end

  // Illegal load types simply retire without a write; misaligned ones trap instead.
  assign write_ok = stage.valid && stage.reg_write && (stage.rd != 5'd0) &&
                    (stage.wb_sel != WB_RSVD) &&
                    !(is_load && (load_misaligned || load_illegal));

  assign rf_write_enable = write_ok;
  assign rf_rd           = write_ok ? stage.rd : 5'd0;
  assign rf_write_data   = write_ok ? wb_value : 64'd0;
  assign exc_misaligned  = stage.valid && is_load && load_misaligned;
  assign retire_valid    = stage.valid && !(is_load && load_misaligned);

`ifdef WB_RETIRE_CNT_EN
  // Counted as the instruction leaves the stage, so a held instruction counts once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_count <= '0;
    end else if (retire_valid && !hold) begin
      retire_count <= retire_count + 1'b1;
    end
  end
`else
  localparam int unused_retire_w = RETIRE_W;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus a randomized
// run against a behavioural model. Define WB_RETIRE_CNT_EN to test retire_count.
module tb_writeback_stage;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        exc;
    logic        retire;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        in_reg_write = 1'b0;
  logic [1:0]  in_wb_sel = '0;
  logic [63:0] in_alu_result = '0;
  logic [63:0] in_pc_plus4 = '0;
  logic [63:0] in_mem_rdata = '0;
  logic [2:0]  in_addr_lo = '0;
  logic [2:0]  in_funct3 = '0;
  logic [4:0]  rf_rd;
  logic [63:0] rf_write_data;
  logic        rf_write_enable;
  logic        exc_misaligned;
  logic        retire_valid;

  int errors = 0;
  int checks = 0;

`ifdef WB_RETIRE_CNT_EN
  localparam int CW = 4;
  logic [CW-1:0] retire_count;
  writeback_stage #(.RETIRE_W(CW)) dut (
`else
  writeback_stage dut (
`endif
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .hold            (hold),
    .flush           (flush),
    .in_rd           (in_rd),
    .in_reg_write    (in_reg_write),
    .in_wb_sel       (in_wb_sel),
    .in_alu_result   (in_alu_result),
    .in_pc_plus4     (in_pc_plus4),
    .in_mem_rdata    (in_mem_rdata),
    .in_addr_lo      (in_addr_lo),
    .in_funct3       (in_funct3),
    .rf_rd           (rf_rd),
    .rf_write_data   (rf_write_data),
    .rf_write_enable (rf_write_enable),
    .exc_misaligned  (exc_misaligned),
    .retire_valid    (retire_valid)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_count    (retire_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic obs_t observed();
    return '{we: rf_write_enable, rd: rf_rd, data: rf_write_data,
             exc: exc_misaligned, retire: retire_valid};
  endfunction

  // Reference: what one instruction should produce, from the ISA-level rules.
  function automatic obs_t model(input logic [4:0] rd, input logic rw,
                                 input logic [1:0] sel, input logic [63:0] alu,
                                 input logic [63:0] pc4, input logic [63:0] rdata,
                                 input logic [2:0] lo, input logic [2:0] f3);
    obs_t        e;
    logic        wr;
    logic [63:0] value;
    logic [63:0] mask;
    int          nbytes;
    e      = '0;
    e.retire = 1'b1;
    wr     = rw && (rd != 0);
    value  = '0;
    case (sel)
      2'd0: value = alu;
      2'd2: value = pc4;
      2'd3: wr = 1'b0;
      default: begin
        if (f3 == 3'd7) begin
          wr = 1'b0;
        end else begin
          nbytes = 1 << f3[1:0];
          if ((int'(lo) % nbytes) != 0) begin
            e.exc = 1'b1;
            e.retire = 1'b0;
            wr = 1'b0;
          end else begin
            value = rdata >> (8 * int'(lo));
            if (nbytes < 8) begin
              mask = (64'd1 << (8 * nbytes)) - 64'd1;
              value = value & mask;
              if (!f3[2] && value[8*nbytes-1]) value = value | ~mask;
            end
          end
        end
      end
    endcase
    if (wr) begin
      e.we = 1'b1;
      e.rd = rd;
      e.data = value;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush = 1'b0;
    hold = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                       input logic [63:0] alu, input logic [63:0] pc4,
                       input logic [63:0] rdata, input logic [2:0] lo,
                       input logic [2:0] f3);
    in_valid = 1'b1;
    in_rd = rd;
    in_reg_write = rw;
    in_wb_sel = sel;
    in_alu_result = alu;
    in_pc_plus4 = pc4;
    in_mem_rdata = rdata;
    in_addr_lo = lo;
    in_funct3 = f3;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    obs_t o;
    idle();
    rst_n = 1'b0;
    tick();
    o = observed();
    checks++;
    if (o !== obs_t'('0)) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", o);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    #2 rst_n = 1'b1;
    tick();
    o = observed();
    checks++;
    if (o !== obs_t'('0)) begin
      errors++;
      $display("FAIL post_reset_outputs: got %h want 0", o);
    end
  endtask

  task automatic test_load_sign();
    obs_t o;
    obs_t exp;
    issue(5'd5, 1'b1, 2'b01, '0, '0, 64'h0000_0000_0000_8000, 3'd1, 3'b000);
    tick();
    o = observed();
    exp = '{we: 1'b1, rd: 5'd5, data: 64'hFFFF_FFFF_FFFF_FF80, exc: 1'b0, retire: 1'b1};
    checks++;
    if (o !== exp) begin
      errors++;
      $display("FAIL lb_sext: got %h want %h", o, exp);
    end
    in_funct3 = 3'b100;
    tick();
    o = observed();
    exp = '{we: 1'b1, rd: 5'd5, data: 64'h80, exc: 1'b0, retire: 1'b1};
    checks++;
    if (o !== exp) begin
      errors++;
      $display("FAIL lbu_zext: got %h want %h", o, exp);
    end
    idle();
    tick();
    o = observed();
    checks++;
    if (o !== obs_t'('0)) begin
      errors++;
      $display("FAIL write_one_cycle: got %h want 0", o);
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    obs_t exp;
    issue(5'd9, 1'b1, 2'b01, '0, '0, 64'h1122_3344_5566_7788, 3'd2, 3'b010);
    tick();
    o = observed();
    exp = '{we: 1'b0, rd: 5'd0, data: 64'd0, exc: 1'b1, retire: 1'b0};
    checks++;
    if (o !== exp) begin
      errors++;
      $display("FAIL lw_misaligned: got %h want %h", o, exp);
    end
    idle();
    tick();
    o = observed();
    checks++;
    if (o !== obs_t'('0)) begin
      errors++;
      $display("FAIL exc_one_pulse: got %h want 0", o);
    end
  endtask

  task automatic test_rd_zero();
    obs_t o;
    obs_t exp;
    issue(5'd0, 1'b1, 2'b00, 64'h1234, '0, '0, 3'd0, 3'd0);
    tick();
    o = observed();
    exp = '{we: 1'b0, rd: 5'd0, data: 64'd0, exc: 1'b0, retire: 1'b1};
    checks++;
    if (o !== exp) begin
      errors++;
      $display("FAIL alu_rd0: got %h want %h", o, exp);
    end
    idle();
    tick();
  endtask

  task automatic test_hold();
    obs_t o;
    obs_t exp;
    issue(5'd1, 1'b1, 2'b10, 64'hDEAD, 64'h1004, '0, 3'd0, 3'd0);
    tick();
    exp = '{we: 1'b1, rd: 5'd1, data: 64'h1004, exc: 1'b0, retire: 1'b1};
    o = observed();
    checks++;
    if (o !== exp) begin
      errors++;
      $display("FAIL pc4_write: got %h want %h", o, exp);
    end
    hold = 1'b1;
    issue(5'd7, 1'b1, 2'b00, 64'hBEEF, '0, '0, 3'd0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_ready[%0d]: got %b want 0", i, in_ready);
      end
      tick();
      o = observed();
      checks++;
      if (o !== exp) begin
        errors++;
        $display("FAIL hold_outputs[%0d]: got %h want %h", i, o, exp);
      end
    end
    idle();
    tick();
    o = observed();
    checks++;
    if (o !== obs_t'('0)) begin
      errors++;
      $display("FAIL hold_no_accept: got %h want 0", o);
    end
  endtask

  task automatic test_flush();
    obs_t o;
    obs_t exp;
    issue(5'd3, 1'b1, 2'b00, 64'hAAAA, '0, '0, 3'd0, 3'd0);
    tick();
    issue(5'd4, 1'b1, 2'b00, 64'hBBBB, '0, '0, 3'd0, 3'd0);
    flush = 1'b1;
    #1;
    o = observed();
    exp = '{we: 1'b1, rd: 5'd3, data: 64'hAAAA, exc: 1'b0, retire: 1'b1};
    checks++;
    if (o !== exp) begin
      errors++;
      $display("FAIL flush_keeps_stage: got %h want %h", o, exp);
    end
    tick();
    o = observed();
    checks++;
    if (o !== obs_t'('0)) begin
      errors++;
      $display("FAIL flush_drop: got %h want 0", o);
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_hold();
    obs_t o;
    issue(5'd2, 1'b1, 2'b00, 64'h55, '0, '0, 3'd0, 3'd0);
    tick();
    hold = 1'b1;
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    o = observed();
    checks++;
    if (o !== obs_t'('0)) begin
      errors++;
      $display("FAIL async_reset_clear: got %h want 0", o);
    end
    tick();
    #2 rst_n = 1'b1;
    tick();
    o = observed();
    checks++;
    if (o !== obs_t'('0)) begin
      errors++;
      $display("FAIL no_write_after_reset: got %h want 0", o);
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    obs_t exp_st;
    obs_t o;
    obs_t nxt;
`ifdef WB_RETIRE_CNT_EN
    logic [CW-1:0] exp_cnt;
    exp_cnt = '0;
`endif
    do_reset();
    exp_st = '0;
    for (int n = 0; n < 400; n++) begin
      hold = ($urandom_range(0, 6) == 0);
      flush = ($urandom_range(0, 9) == 0);
      issue(($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
            ($urandom_range(0, 4) != 0), 2'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            3'($urandom), 3'($urandom));
      in_valid = ($urandom_range(0, 3) != 0);
      nxt = model(in_rd, in_reg_write, in_wb_sel, in_alu_result, in_pc_plus4,
                  in_mem_rdata, in_addr_lo, in_funct3);
      #1;
      checks++;
      if (in_ready !== !hold) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b want %b", n, in_ready, !hold);
      end
      if (!hold) begin
`ifdef WB_RETIRE_CNT_EN
        if (exp_st.retire) exp_cnt = exp_cnt + 1'b1;
`endif
        exp_st = (in_valid && !flush) ? nxt : obs_t'('0);
      end
      tick();
      o = observed();
      checks++;
      if (o !== exp_st) begin
        errors++;
        $display("FAIL rand_outputs[%0d]: got %h want %h", n, o, exp_st);
      end
`ifdef WB_RETIRE_CNT_EN
      checks++;
      if (retire_count !== exp_cnt) begin
        errors++;
        $display("FAIL rand_count[%0d]: got %0d want %0d", n, retire_count, exp_cnt);
      end
`endif
    end
    idle();
    tick();
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic test_retire_count_wrap();
    logic [CW-1:0] all_ones;
    do_reset();
    all_ones = '1;
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      issue(5'd6, 1'b1, 2'b00, 64'(i), '0, '0, 3'd0, 3'd0);
      tick();
    end
    idle();
    tick();
    checks++;
    if (retire_count !== all_ones) begin
      errors++;
      $display("FAIL count_all_ones: got %h want %h", retire_count, all_ones);
    end
    issue(5'd6, 1'b1, 2'b00, 64'h1, '0, '0, 3'd0, 3'd0);
    tick();
    idle();
    tick();
    checks++;
    if (retire_count !== '0) begin
      errors++;
      $display("FAIL count_wrap: got %h want 0", retire_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_sign();
    test_misaligned();
    test_rd_zero();
    test_hold();
    test_flush();
    test_reset_mid_hold();
    test_random();
`ifdef WB_RETIRE_CNT_EN
    test_retire_count_wrap();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
